// File: rtl/pic_inta_control_pkg.sv
// Shared constants, state encodings and helpers for the 8259A-style interrupt controller.
// The find-first helper is common to priority resolution and non-specific EOI.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam logic [2:0] SPURIOUS_IR = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACK1 = 2'd1;
  localparam state_t ACK2 = 2'd2;

  localparam logic [2:0] OCW2_NSEOI = 3'b001;
  localparam logic [2:0] OCW2_SEOI  = 3'b011;

  localparam logic READ_IRR = 1'b0;
  localparam logic READ_ISR = 1'b1;

  typedef struct packed {
    logic [4:0] vector_base;
    logic       ltim;
    logic       aeoi;
    logic       init_done;
  } pic_cfg_t;

  // Index of the lowest set bit (IR0 is highest priority); 0 when the vector is empty.
  function automatic logic [2:0] find_first(input logic [NUM_IR-1:0] v);
    find_first = 3'd0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (v[i]) find_first = i[2:0];
    end
  endfunction

endpackage

// File: rtl/pic_inta_control_if.sv
// Command, interrupt-request, acknowledge and status signals of the interrupt controller.
// master drives commands and requests; slave is the controller itself.
interface pic_inta_if;

  logic [3:0] icw_strobe;
  logic [2:0] ocw_strobe;
  logic [7:0] cmd_data;
  logic [7:0] ir_in;
  logic       inta_n;

  logic       int_out;
  logic [7:0] dout;
  logic       dout_oe;
  logic [7:0] irr_q;
  logic [7:0] isr_q;
  logic [7:0] imr_q;
  logic       read_sel;

  modport master (
    output icw_strobe, ocw_strobe, cmd_data, ir_in, inta_n,
    input  int_out, dout, dout_oe, irr_q, isr_q, imr_q, read_sel
  );

  modport slave (
    input  icw_strobe, ocw_strobe, cmd_data, ir_in, inta_n,
    output int_out, dout, dout_oe, irr_q, isr_q, imr_q, read_sel
  );

endinterface

// File: rtl/pic_inta_control_priority_resolver.sv
// Fixed fully-nested priority resolution: picks the best unmasked request and reports
// whether it may interrupt the highest-priority routine currently in service.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  output logic       req,
  output logic [2:0] p,
  output logic [2:0] isr_top
);

  logic [7:0] pending;

  assign pending = irr & ~imr;
  assign p       = find_first(pending);
  assign isr_top = find_first(isr);

  // A request only pre-empts when it is strictly higher priority than everything in service.
  always_comb begin
    req = 1'b0;
    if (pending != 8'h00) begin
      req = (isr == 8'h00) || (p < isr_top);
    end
  end

endmodule

// File: rtl/pic_inta_control.sv
// Interrupt request/service/mask state, INT generation and the two-pulse INTA
// vector sequence, configured by the ICW/OCW strobes from the read/write stage.
module pic_inta_control
  import pic_pkg::*;
(
  input logic       clk,
  input logic       rst,
  pic_inta_if.slave bus
);

  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] imr;
  logic [7:0] ir_prev;
  pic_cfg_t   cfg;
  state_t     state;
  logic [2:0] sel;
  logic       spurious;
  logic       inta_prev;
  logic       int_out;
  logic [7:0] dout;
  logic       dout_oe;
  logic       read_sel;

  logic       req_raw;
  logic       req;
  logic [2:0] p;
  logic [2:0] isr_top;
  logic       inta_fall;
  logic       ack;
  logic       release_ack;

  logic       icw1, icw2, icw4;
  logic       ocw1, ocw2, ocw3;
  logic       eoi_ns, eoi_s;
  logic [7:0] irr_next;
  logic [7:0] isr_next;

  pic_priority_resolver u_prio (
    .irr     (irr),
    .imr     (imr),
    .isr     (isr),
    .req     (req_raw),
    .p       (p),
    .isr_top (isr_top)
  );

  assign req         = cfg.init_done & req_raw;
  assign inta_fall   = inta_prev & ~bus.inta_n;
  assign ack         = (state == IDLE) & inta_fall & req;
  assign release_ack = (state == ACK2) & bus.inta_n & cfg.aeoi & ~spurious;

  // Only one strobe acts per cycle: lowest ICW first, then lowest OCW (ICW3 just blocks).
  always_comb begin
    icw1 = bus.icw_strobe[0];
    icw2 = bus.icw_strobe[1] & ~bus.icw_strobe[0];
    icw4 = bus.icw_strobe[3] & ~(|bus.icw_strobe[2:0]);
    ocw1 = ~(|bus.icw_strobe) & bus.ocw_strobe[0];
    ocw2 = ~(|bus.icw_strobe) & bus.ocw_strobe[1] & ~bus.ocw_strobe[0];
    ocw3 = ~(|bus.icw_strobe) & bus.ocw_strobe[2] & ~(|bus.ocw_strobe[1:0]);
  end

  assign eoi_ns = ocw2 & (bus.cmd_data[7:5] == OCW2_NSEOI) & (isr != 8'h00);
  assign eoi_s  = ocw2 & (bus.cmd_data[7:5] == OCW2_SEOI);

  // Acknowledge clear is applied last so it beats a same-cycle request capture.
  always_comb begin
    irr_next = cfg.ltim ? bus.ir_in : (irr | (bus.ir_in & ~ir_prev));
    if (ack) irr_next[p] = 1'b0;
  end

  always_comb begin
    isr_next = isr;
    if (eoi_ns)      isr_next[isr_top]           = 1'b0;
    if (eoi_s)       isr_next[bus.cmd_data[2:0]] = 1'b0;
    if (release_ack) isr_next[sel]               = 1'b0;
    if (ack)         isr_next[p]                 = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irr       <= 8'h00;
      isr       <= 8'h00;
      imr       <= 8'hFF;
      ir_prev   <= 8'h00;
      cfg       <= '0;
      state     <= IDLE;
      sel       <= 3'd0;
      spurious  <= 1'b0;
      inta_prev <= 1'b1;
      int_out   <= 1'b0;
      dout      <= 8'h00;
      dout_oe   <= 1'b0;
      read_sel  <= READ_IRR;
    end else begin
      ir_prev   <= bus.ir_in;
      inta_prev <= bus.inta_n;
      if (icw1) begin
        irr           <= 8'h00;
        isr           <= 8'h00;
        imr           <= 8'h00;
        cfg.ltim      <= bus.cmd_data[3];
        cfg.aeoi      <= 1'b0;
        cfg.init_done <= 1'b0;
        read_sel      <= READ_IRR;
        state         <= IDLE;
        int_out       <= 1'b0;
        dout_oe       <= 1'b0;
      end else begin
        irr     <= irr_next;
        isr     <= isr_next;
        int_out <= (state == IDLE) & ~inta_fall & req;
        if (icw2) begin
          cfg.vector_base <= bus.cmd_data[7:3];
          cfg.init_done   <= 1'b1;
        end
        if (icw4) cfg.aeoi <= bus.cmd_data[1];
        if (ocw1) imr <= bus.cmd_data;
        if (ocw3 && bus.cmd_data[1]) read_sel <= bus.cmd_data[0];

        case (state)
          IDLE: begin
            if (inta_fall) begin
              state    <= ACK1;
              sel      <= req ? p : SPURIOUS_IR;
              spurious <= ~req;
            end
          end
          ACK1: begin
            if (inta_fall) begin
              state   <= ACK2;
              dout    <= {cfg.vector_base, sel};
              dout_oe <= 1'b1;
            end
          end
          ACK2: begin
            if (bus.inta_n) begin
              state   <= IDLE;
              dout_oe <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.int_out  = int_out;
  assign bus.dout     = dout;
  assign bus.dout_oe  = dout_oe;
  assign bus.irr_q    = irr;
  assign bus.isr_q    = isr;
  assign bus.imr_q    = imr;
  assign bus.read_sel = read_sel;

endmodule

// File: tb/tb_pic_inta_control.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// cycle-level behavioural model of the interrupt controller.
module tb_pic_inta_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] icw = '0;
  logic [2:0] ocw = '0;
  logic [7:0] cmd = '0;
  logic [7:0] ir = '0;
  logic       inta_n = 1'b1;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_irr, m_isr, m_imr, m_irprev, m_dout;
  int         m_vb, m_phase, m_sel;
  bit         m_ltim, m_aeoi, m_init, m_rsel, m_int, m_oe, m_spur, m_intaprev;

  always #5 clk = ~clk;

  pic_inta_if bus ();

  assign bus.icw_strobe = icw;
  assign bus.ocw_strobe = ocw;
  assign bus.cmd_data   = cmd;
  assign bus.ir_in      = ir;
  assign bus.inta_n     = inta_n;

  pic_inta_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int lowest(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return 8;
  endfunction

  function automatic int first_strobe(input logic [3:0] i, input logic [2:0] o);
    for (int k = 0; k < 4; k++) if (i[k]) return k;
    for (int k = 0; k < 3; k++) if (o[k]) return 4 + k;
    return -1;
  endfunction

  // Advance the model by one rising edge using the inputs held across that edge.
  task automatic model_edge();
    int p, top, which;
    bit fall, req;
    logic [7:0] nirr, nisr;
    p     = lowest(m_irr & ~m_imr);
    top   = lowest(m_isr);
    req   = m_init && (p < top);
    fall  = m_intaprev && !inta_n;
    which = first_strobe(icw, ocw);
    if (rst) begin
      m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_irprev = 8'h00; m_dout = 8'h00;
      m_vb = 0; m_phase = 0; m_sel = 0; m_ltim = 0; m_aeoi = 0; m_init = 0;
      m_rsel = 0; m_int = 0; m_oe = 0; m_spur = 0; m_intaprev = 1;
      return;
    end
    if (which == 0) begin
      m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00;
      m_ltim = cmd[3]; m_aeoi = 0; m_init = 0; m_rsel = 0;
      m_phase = 0; m_int = 0; m_oe = 0;
    end else begin
      nirr = m_ltim ? ir : (m_irr | (ir & ~m_irprev));
      nisr = m_isr;
      if (which == 5) begin
        if (cmd[7:5] == 3'b001 && top < 8) nisr[top] = 1'b0;
        if (cmd[7:5] == 3'b011) nisr[cmd[2:0]] = 1'b0;
      end
      if (m_phase == 2 && inta_n && m_aeoi && !m_spur) nisr[m_sel] = 1'b0;
      m_int = (m_phase == 0) && !fall && req;
      case (m_phase)
        0: if (fall) begin
          m_phase = 1;
          m_spur  = !req;
          m_sel   = req ? p : 7;
          if (req) begin
            nisr[p] = 1'b1;
            nirr[p] = 1'b0;
          end
        end
        1: if (fall) begin
          m_phase = 2;
          m_oe    = 1;
          m_dout  = 8'(m_vb * 8 + m_sel);
        end
        default: if (inta_n) begin
          m_phase = 0;
          m_oe    = 0;
        end
      endcase
      if (which == 1) begin m_vb = int'(cmd[7:3]); m_init = 1; end
      if (which == 3) m_aeoi = cmd[1];
      if (which == 4) m_imr = cmd;
      if (which == 6 && cmd[1]) m_rsel = cmd[0];
      m_irr = nirr;
      m_isr = nisr;
    end
    m_irprev   = ir;
    m_intaprev = inta_n;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%02h expected=%02h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check_output("int_out", {7'd0, bus.int_out}, {7'd0, m_int});
    check_output("dout_oe", {7'd0, bus.dout_oe}, {7'd0, m_oe});
    check_output("dout", bus.dout, m_dout);
    check_output("irr_q", bus.irr_q, m_irr);
    check_output("isr_q", bus.isr_q, m_isr);
    check_output("imr_q", bus.imr_q, m_imr);
    check_output("read_sel", {7'd0, bus.read_sel}, {7'd0, m_rsel});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    icw = '0;
    ocw = '0;
    check_model();
  endtask

  task automatic apply_icw(input int n, input logic [7:0] data);
    icw = 4'(1 << n);
    cmd = data;
    tick();
  endtask

  task automatic apply_ocw(input int n, input logic [7:0] data);
    ocw = 3'(1 << n);
    cmd = data;
    tick();
  endtask

  task automatic init_pic(input logic [7:0] icw1_data);
    apply_icw(0, icw1_data);
    apply_icw(1, 8'h40);
    apply_ocw(0, 8'h00);
  endtask

  task automatic pulse_ir(input logic [7:0] lines);
    ir = lines;
    tick();
    ir = 8'h00;
    tick();
  endtask

  task automatic inta_first();
    inta_n = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
  endtask

  task automatic inta_second();
    inta_n = 1'b0;
    tick();
  endtask

  task automatic inta_release();
    inta_n = 1'b1;
    tick();
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rst_imr", bus.imr_q, 8'hFF);
    check_output("rst_int", {7'd0, bus.int_out}, 8'h00);

    // scenario 1: IR3 edge, one-cycle INT latency, vector 0x43
    init_pic(8'h10);
    ir = 8'h08;
    tick();
    check_output("t1_irr", bus.irr_q, 8'h08);
    check_output("t1_int_early", {7'd0, bus.int_out}, 8'h00);
    ir = 8'h00;
    tick();
    check_output("t1_int", {7'd0, bus.int_out}, 8'h01);
    inta_first();
    inta_second();
    check_output("t1_dout", bus.dout, 8'h43);
    check_output("t1_oe", {7'd0, bus.dout_oe}, 8'h01);
    check_output("t1_isr", bus.isr_q, 8'h08);
    check_output("t1_irr_ack", bus.irr_q, 8'h00);
    check_output("t1_int_ack", {7'd0, bus.int_out}, 8'h00);
    inta_release();
    check_output("t1_oe_rel", {7'd0, bus.dout_oe}, 8'h00);

    // scenario 2: non-specific EOI, masking
    apply_ocw(1, 8'h20);
    check_output("t2_isr", bus.isr_q, 8'h00);
    apply_ocw(0, 8'h20);
    pulse_ir(8'h20);
    tick();
    check_output("t2_irr", bus.irr_q, 8'h20);
    check_output("t2_masked", {7'd0, bus.int_out}, 8'h00);
    apply_ocw(0, 8'h00);
    tick();
    check_output("t2_unmasked", {7'd0, bus.int_out}, 8'h01);

    // scenario 3: nesting with IR2 in service
    init_pic(8'h10);
    pulse_ir(8'h04);
    inta_first(); inta_second(); inta_release();
    check_output("t3_isr2", bus.isr_q, 8'h04);
    pulse_ir(8'h40);
    tick();
    check_output("t3_low_blocked", {7'd0, bus.int_out}, 8'h00);
    pulse_ir(8'h02);
    check_output("t3_high_int", {7'd0, bus.int_out}, 8'h01);
    inta_first(); inta_second();
    check_output("t3_dout", bus.dout, 8'h41);
    inta_release();
    check_output("t3_isr_nest", bus.isr_q, 8'h06);
    apply_ocw(1, 8'h61);
    check_output("t3_seoi", bus.isr_q, 8'h04);

    // scenario 4: automatic EOI and spurious acknowledge
    apply_icw(0, 8'h10);
    apply_icw(1, 8'h40);
    apply_icw(3, 8'h02);
    apply_ocw(0, 8'h00);
    pulse_ir(8'h01);
    inta_first(); inta_second();
    check_output("t4_dout", bus.dout, 8'h40);
    check_output("t4_isr_held", bus.isr_q, 8'h01);
    inta_release();
    check_output("t4_aeoi", bus.isr_q, 8'h00);
    inta_first(); inta_second();
    check_output("t4_spurious", bus.dout, 8'h47);
    inta_release();
    check_output("t4_spur_isr", bus.isr_q, 8'h00);

    // scenario 5: level mode re-asserts, edge mode does not
    init_pic(8'h18);
    ir = 8'h10;
    tick();
    tick();
    inta_n = 1'b0;
    tick();
    check_output("t5_lvl_ack_clr", bus.irr_q, 8'h00);
    inta_n = 1'b1;
    tick();
    check_output("t5_lvl_reassert", bus.irr_q, 8'h10);
    inta_second(); inta_release();
    ir = 8'h00;
    tick();
    apply_ocw(1, 8'h20);
    init_pic(8'h10);
    ir = 8'h10;
    tick();
    tick();
    inta_first(); inta_second(); inta_release();
    check_output("t5_edge_hold", bus.irr_q, 8'h00);
    ir = 8'h00;
    tick();
    ir = 8'h10;
    tick();
    check_output("t5_edge_rearm", bus.irr_q, 8'h10);
    ir = 8'h00;

    // scenario 6: reset and ICW1 abort the acknowledge sequence
    init_pic(8'h10);
    pulse_ir(8'h08);
    inta_first();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("t6_rst_oe", {7'd0, bus.dout_oe}, 8'h00);
    check_output("t6_rst_imr", bus.imr_q, 8'hFF);
    check_output("t6_rst_int", {7'd0, bus.int_out}, 8'h00);
    init_pic(8'h10);
    pulse_ir(8'h08);
    inta_n = 1'b0;
    tick();
    check_output("t6_idle_after_rst", {7'd0, bus.dout_oe}, 8'h00);
    inta_n = 1'b1;
    tick();
    inta_second();
    icw = 4'b0001;
    cmd = 8'h10;
    tick();
    check_output("t6_icw1_oe", {7'd0, bus.dout_oe}, 8'h00);
    check_output("t6_icw1_imr", bus.imr_q, 8'h00);
    inta_release();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if ($urandom_range(0, 3) == 0) ir = 8'($urandom & $urandom);
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      rst = (r == 0);
      cmd = 8'($urandom);
      if (r >= 1 && r < 3) icw = 4'b0001;
      else if (r < 12) icw = 4'b0010;
      else if (r < 14) icw = 4'b0100;
      else if (r < 18) icw = 4'b1000;
      else if (r < 28) begin
        ocw = 3'b001;
        cmd = 8'($urandom & $urandom);
      end else if (r < 34) begin
        ocw = 3'b010;
        cmd[7:5] = 3'b001;
      end else if (r < 40) begin
        ocw = 3'b010;
        cmd[7:5] = 3'b011;
      end else if (r < 42) ocw = 3'b010;
      else if (r < 46) ocw = 3'b100;
      else if (r < 48) begin
        icw = 4'($urandom) & 4'b1110;
        ocw = 3'($urandom);
      end
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
